minterm_sweep_ctrl: RTL and testbench
=====================================

MINTERM_SWEEP_CTRL -- requirements
Module: minterm_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_W, 4, width of the settle-cycle count input.
REQ-002 The block SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port clear  in  1  synchronous, active-low reset.
REQ-004 The block SHALL have port start  in  1  sweep request, sampled only in IDLE.
REQ-005 The block SHALL have port abort  in  1  abandon the sweep; honoured in any non-IDLE state.
REQ-006 The block SHALL have port hold_cycles  in  HOLD_W  settle cycles per minterm (0 allowed).
REQ-007 The block SHALL have port f_in  in  1  combinational function-under-test result for the current minterm.
REQ-008 The block SHALL have port q_in  in  1  Q of the T flip-flop being sequenced.
REQ-009 The block SHALL have port minterm  out  4  applied inputs; bit3=a, bit2=b, bit1=c, bit0=d.
REQ-010 The block SHALL have port ff_clr  out  1  active-high clear to the T flip-flop.
REQ-011 The block SHALL have port ff_t  out  1  gated T input to the T flip-flop.
REQ-012 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 The block SHALL have port done  out  1  one-cycle pulse at sweep completion.
REQ-014 The block SHALL have port truth  out  16  captured Q per minterm; bit m = result of minterm m.
REQ-015 The block SHALL have port mism_cnt  out  5  count of minterms where q_in differed from the latched f_in.

Function
REQ-016 The FSM SHALL have states IDLE, CLR, TOG, SETTLE, SAMPLE and DONE.
REQ-017 From IDLE, start=1 SHALL move to CLR with minterm=0, truth=0 and mism_cnt=0; start is ignored in any other state.
REQ-018 CLR SHALL last 1 cycle with ff_clr=1 and ff_t=0, then move to TOG.
REQ-019 TOG SHALL last 1 cycle with ff_t=f_in and ff_clr=0; f_in SHALL be latched into f_lat at the end of TOG.
REQ-020 SETTLE SHALL last exactly hold_cycles cycles with ff_t=0; hold_cycles=0 SHALL go TOG->SAMPLE directly.
REQ-021 hold_cycles SHALL be captured at start; changes mid-sweep SHALL have no effect.
REQ-022 SAMPLE SHALL last 1 cycle and SHALL write q_in into truth[minterm].
REQ-023 In SAMPLE, mism_cnt SHALL increment when q_in != f_lat, saturating at 16.
REQ-024 From SAMPLE with minterm<15, the FSM SHALL increment minterm and go to CLR; with minterm=15 it SHALL go to DONE, and minterm SHALL NOT wrap.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE; truth, mism_cnt and minterm SHALL hold until the next start.
REQ-026 Per-minterm time SHALL be 3+H cycles; done SHALL be high exactly 16*(3+H)+1 cycles after the edge that sampled start.
REQ-027 In non-IDLE states, abort=1 SHALL force IDLE at the next edge with ff_clr=0 and ff_t=0, no done pulse, and truth/mism_cnt holding partial results.
REQ-028 If abort and the SAMPLE of minterm 15 coincide, abort SHALL win: the sample is not written and done is not pulsed.
REQ-029 ff_t SHALL be 0 in every state except TOG; ff_clr SHALL be 1 only in CLR.

Reset
REQ-030 clear=0 at a rising edge SHALL force IDLE, minterm=0, ff_clr=0, ff_t=0, busy=0, done=0, truth=0, mism_cnt=0 and f_lat=0.
REQ-031 Reset SHALL override start and abort, including when asserted mid-sweep.

Structure
REQ-032 A shared package SHALL hold the state enum, N_MINTERMS=16, and the CLR/TOG/SAMPLE fixed-cycle constants.
REQ-033 The settle down-counter SHALL be a sub-module named settle_timer (load, count, zero flag).
REQ-034 The block SHALL contain no combinational path from f_in or q_in to any output.

Verification
REQ-035 Bench SHALL drive f=(c|d)&(b|c)&(b|d)&(~b|~c|~d) with a real T-FF, H=0 -> truth=16'h6868, mism_cnt=0, done at cycle 49.
REQ-036 Bench SHALL repeat with H=5 -> identical truth, with done at cycle 16*8+1=129.
REQ-037 Bench SHALL tie q_in=0 and use the same f -> truth=16'h0000, mism_cnt=6.
REQ-038 Bench SHALL raise abort during SETTLE of minterm 4 -> IDLE next cycle, no done, truth bits 3 and 4 as captured, bits 5-15 =0.
REQ-039 Bench SHALL apply clear=0 mid-sweep then start again -> all outputs reset, and the new sweep completes normally.
REQ-040 Bench SHALL pulse start while busy -> ignored, with no restart and no change to timing.

Source files
------------

// File: rtl/minterm_sweep_ctrl_pkg.sv
// Shared definitions for the minterm sweep controller: FSM state encoding,
// the size of the sweep and the fixed per-minterm phase lengths.
package minterm_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        TOG,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam int N_MINTERMS    = 16;
    localparam int CLR_CYCLES    = 1;
    localparam int TOG_CYCLES    = 1;
    localparam int SAMPLE_CYCLES = 1;

    // Cycles spent on one minterm for a given settle count.
    function automatic int minterm_period(input int hold);
        return CLR_CYCLES + TOG_CYCLES + SAMPLE_CYCLES + hold;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle down-counter: loaded once per minterm, decremented while counting,
// and reports when it has reached zero.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over counting, and the counter stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Minterm sweep controller: walks all 16 input combinations of a function
// under test, drives a T flip-flop with the function result for each one,
// and records the flip-flop output and any disagreement with the function.
// All outputs come from registers so f_in and q_in never reach an output
// combinationally; ff_t is registered from f_in while the minterm is already
// stable during CLR.
module minterm_sweep_ctrl
    import minterm_sweep_ctrl_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              f_in,
    input  logic              q_in,
    output logic [3:0]        minterm,
    output logic              ff_clr,
    output logic              ff_t,
    output logic              busy,
    output logic              done,
    output logic [15:0]       truth,
    output logic [4:0]        mism_cnt
);

    localparam logic [3:0] LAST_MINTERM = 4'(N_MINTERMS - 1);
    localparam logic [4:0] MISM_MAX     = 5'(N_MINTERMS);

    state_e             state_q, state_d;
    logic [3:0]         minterm_q, minterm_d;
    logic [15:0]        truth_q, truth_d;
    logic [4:0]         mism_q, mism_d;
    logic               f_lat_q, f_lat_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               ff_t_q, ff_t_d;
    logic               tmr_load;
    logic               tmr_count;
    logic               tmr_zero;

    settle_timer #(
        .W(HOLD_W)
    ) u_settle_timer (
        .clk      (clk),
        .clear    (clear),
        .load     (tmr_load),
        .load_val (hold_q - HOLD_W'(1)),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Next-state and datapath updates; abort overrides every non-IDLE move.
    always_comb begin
        state_d   = state_q;
        minterm_d = minterm_q;
        truth_d   = truth_q;
        mism_d    = mism_q;
        f_lat_d   = f_lat_q;
        hold_d    = hold_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLR;
                    minterm_d = '0;
                    truth_d   = '0;
                    mism_d    = '0;
                    hold_d    = hold_cycles;
                end
            end
            CLR: begin
                state_d = TOG;
            end
            TOG: begin
                f_lat_d = f_in;
                if (hold_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            SAMPLE: begin
                truth_d[minterm_q] = q_in;
                if ((q_in != f_lat_q) && (mism_q != MISM_MAX)) begin
                    mism_d = mism_q + 5'd1;
                end
                if (minterm_q == LAST_MINTERM) begin
                    state_d = DONE;
                end else begin
                    minterm_d = minterm_q + 4'd1;
                    state_d   = CLR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && abort) begin
            state_d   = IDLE;
            minterm_d = minterm_q;
            truth_d   = truth_q;
            mism_d    = mism_q;
            f_lat_d   = f_lat_q;
            tmr_load  = 1'b0;
            tmr_count = 1'b0;
        end

        ff_t_d = (state_d == TOG) ? f_in : 1'b0;
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q   <= IDLE;
            minterm_q <= '0;
            truth_q   <= '0;
            mism_q    <= '0;
            f_lat_q   <= 1'b0;
            hold_q    <= '0;
            ff_t_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            minterm_q <= minterm_d;
            truth_q   <= truth_d;
            mism_q    <= mism_d;
            f_lat_q   <= f_lat_d;
            hold_q    <= hold_d;
            ff_t_q    <= ff_t_d;
        end
    end

    assign minterm  = minterm_q;
    assign truth    = truth_q;
    assign mism_cnt = mism_q;
    assign ff_t     = ff_t_q;
    assign ff_clr   = (state_q == CLR);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Bench for minterm_sweep_ctrl: a real T flip-flop and the function
// f=(c|d)&(b|c)&(b|d)&(~b|~c|~d) around the controller; expected sweep
// results are queued when a sweep starts and checked on the done pulse.
module tb_minterm_sweep_ctrl;

    typedef struct {
        logic [15:0] truth;
        int          mism;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        clear;
    logic        start;
    logic        abort;
    logic [3:0]  hold_cycles;
    logic        f_in;
    logic        q_in;
    logic [3:0]  minterm;
    logic        ff_clr;
    logic        ff_t;
    logic        busy;
    logic        done;
    logic [15:0] truth;
    logic [4:0]  mism_cnt;

    logic        q_tff;
    logic [1:0]  q_mode;
    logic        b, c, d;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          start_edge = 0;
    int          checks = 0;
    int          failures = 0;

    minterm_sweep_ctrl #(
        .HOLD_W(4)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .abort       (abort),
        .hold_cycles (hold_cycles),
        .f_in        (f_in),
        .q_in        (q_in),
        .minterm     (minterm),
        .ff_clr      (ff_clr),
        .ff_t        (ff_t),
        .busy        (busy),
        .done        (done),
        .truth       (truth),
        .mism_cnt    (mism_cnt)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running edge counter used for done latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Function under test driven from the applied minterm.
    assign b    = minterm[2];
    assign c    = minterm[1];
    assign d    = minterm[0];
    assign f_in = (c | d) & (b | c) & (b | d) & (~b | ~c | ~d);

    // Real T flip-flop with synchronous clear.
    always @(posedge clk) begin
        if (!clear || ff_clr) q_tff <= 1'b0;
        else if (ff_t)        q_tff <= ~q_tff;
    end

    // Q source: the real flip-flop, or a tie-off.
    always_comb begin
        q_in = q_tff;
        if (q_mode == 2'd1) q_in = 1'b0;
        if (q_mode == 2'd2) q_in = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest queued sweep.
    always @(negedge clk) begin
        if (clear && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("done_truth", 32'(truth), 32'(e.truth));
                checkOutput("done_mism", 32'(mism_cnt), 32'(e.mism));
                checkOutput("done_minterm", 32'(minterm), 32'd15);
                checkOutput("done_latency", 32'(cyc - start_edge + 1), 32'(e.cycles));
            end
        end
    end

    task automatic startSweep(input int h, input logic [1:0] qm);
        @(negedge clk);
        hold_cycles = 4'(h);
        q_mode      = qm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start_edge  = cyc;
        start       = 1'b0;
        hold_cycles = 4'd9;
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, "_minterm"}, 32'(minterm), 32'd0);
        checkOutput({tag, "_ff_clr"}, 32'(ff_clr), 32'd0);
        checkOutput({tag, "_ff_t"}, 32'(ff_t), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_truth"}, 32'(truth), 32'd0);
        checkOutput({tag, "_mism"}, 32'(mism_cnt), 32'd0);
    endtask

    // Full sweep: queue the expectation, optionally pulse start while busy,
    // wait (bounded) for return to IDLE and confirm results are held.
    task automatic applyStimulus(input int h, input logic [1:0] qm,
                                 input logic [15:0] etruth, input int emism,
                                 input int pulse_at);
        exp_t e;
        bit   finished;
        e.truth  = etruth;
        e.mism   = emism;
        e.cycles = 16 * (3 + h) + 1;
        sb_q.push_back(e);
        startSweep(h, qm);
        finished = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            start = (n == pulse_at);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL sweep_timeout: got busy=1 expected idle within 600 cycles");
        end
        checkOutput("done_consumed", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("hold_truth", 32'(truth), 32'(etruth));
        checkOutput("hold_mism", 32'(mism_cnt), 32'(emism));
        checkOutput("hold_minterm", 32'(minterm), 32'd15);
        checkOutput("hold_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        clear       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        hold_cycles = 4'd0;
        q_mode      = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllReset("reset");
        clear = 1'b1;

        // Real T-FF, no settle time, then five settle cycles.
        applyStimulus(0, 2'd0, 16'h6868, 0, 0);
        applyStimulus(5, 2'd0, 16'h6868, 0, 0);

        // Q tied low: every minterm where f=1 mismatches.
        applyStimulus(2, 2'd1, 16'h0000, 6, 0);

        // Start pulsed mid-sweep must not restart or stretch the sweep.
        applyStimulus(1, 2'd0, 16'h6868, 0, 20);

        // Abort during SETTLE of minterm 4 (H=3: SETTLE spans cycles 27..29).
        startSweep(3, 2'd0);
        repeat (27) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_abort_minterm", 32'(minterm), 32'd4);
        checkOutput("pre_abort_ff_t", 32'(ff_t), 32'd0);
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ff_t", 32'(ff_t), 32'd0);
        checkOutput("abort_ff_clr", 32'(ff_clr), 32'd0);
        checkOutput("abort_truth", 32'(truth), 32'h0008);
        checkOutput("abort_mism", 32'(mism_cnt), 32'd0);
        repeat (60) @(negedge clk);
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);

        // Abort colliding with SAMPLE of minterm 15 with Q tied high.
        startSweep(0, 2'd2);
        repeat (47) @(posedge clk);
        @(negedge clk);
        checkOutput("last_sample_minterm", 32'(minterm), 32'd15);
        checkOutput("last_sample_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("late_abort_busy", 32'(busy), 32'd0);
        checkOutput("late_abort_truth", 32'(truth), 32'h7FFF);
        checkOutput("late_abort_mism", 32'(mism_cnt), 32'd9);
        repeat (5) @(negedge clk);

        // Clear mid-sweep, then a normal sweep afterwards.
        startSweep(0, 2'd0);
        repeat (20) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        checkAllReset("midclear");
        clear = 1'b1;
        applyStimulus(0, 2'd0, 16'h6868, 0, 0);

        checkOutput("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
